// File: rtl/instn_encoder_if.sv
// Command and instruction-stream bundle around the instruction encoder.
// master = encoder side (accepts commands, sources instructions); slave = environment.
interface instn_encoder_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_type;
    logic [4:0]    cmd_rs;
    logic [4:0]    cmd_rt;
    logic [4:0]    cmd_rd;
    logic [4:0]    cmd_shamt;
    logic [5:0]    cmd_funct;
    logic [15:0]   cmd_imm;
    logic [31:0]   instn;
    logic          instn_valid;
    logic          instn_ready;
    logic [CW-1:0] fifo_count;
    logic          err_pulse;
    logic [7:0]    err_cnt;

    modport master (
        input  cmd_valid, cmd_type, cmd_rs, cmd_rt, cmd_rd, cmd_shamt, cmd_funct, cmd_imm,
        input  instn_ready,
        output cmd_ready, instn, instn_valid, fifo_count, err_pulse, err_cnt
    );

    modport slave (
        output cmd_valid, cmd_type, cmd_rs, cmd_rt, cmd_rd, cmd_shamt, cmd_funct, cmd_imm,
        output instn_ready,
        input  cmd_ready, instn, instn_valid, fifo_count, err_pulse, err_cnt
    );
endinterface

// File: rtl/instn_encoder.sv
// Encodes field commands into 32-bit words, buffers them and streams them out with NOP bubbles on RAW hazards.
// Latency: word visible one edge after accept; cmd_ready drops when the FIFO is full, output holds while instn_ready=0.
module instn_encoder #(
    parameter int DEPTH   = 4,
    parameter int HAZ_GAP = 2
) (
    input  logic            clk,
    input  logic            rst,
    instn_encoder_if.master bus
);
    localparam int         AW      = $clog2(DEPTH);
    localparam int         CW      = AW + 1;
    localparam bit         HAZ_EN  = (HAZ_GAP > 0);
    localparam logic [7:0] GAP_MAX = 8'(HAZ_GAP);

    localparam logic [1:0] T_RTYPE = 2'd0;
    localparam logic [1:0] T_ADDI  = 2'd1;
    localparam logic [1:0] T_SET   = 2'd2;
    localparam logic [1:0] T_RSVD  = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BUBBLE} state_t;

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    state_t        r_state;
    logic [31:0]   r_instn;
    logic          r_instn_vld;
    logic [4:0]    r_last_dst;
    logic [7:0]    r_gap;
    logic          r_err_pulse;
    logic [7:0]    r_err_cnt;

    logic          w_cmd_rdy;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_word;
    logic [CW-1:0] w_cnt_kept;
    logic [CW-1:0] w_cnt_nxt;
    logic [AW-1:0] w_rd_nxt;
    logic [31:0]   w_head_nxt;
    logic [4:0]    w_issue_dst;
    logic [4:0]    w_last_dst_nxt;
    logic [7:0]    w_gap_nxt;
    logic          w_head_is_r;
    logic          w_hazard_nxt;

    assign w_cmd_rdy = !rst && (r_count < CW'(DEPTH));
    assign w_accept  = bus.cmd_valid && w_cmd_rdy;
    assign w_push    = w_accept && (bus.cmd_type != T_RSVD);
    assign w_pop     = r_instn_vld && bus.instn_ready && (r_state == S_HEAD);

    always_comb begin
        w_word = 32'h0;
        case (bus.cmd_type)
            T_RTYPE: w_word = {6'b000000, bus.cmd_rs, bus.cmd_rt, bus.cmd_rd, bus.cmd_shamt, bus.cmd_funct};
            T_ADDI:  w_word = {6'b001000, bus.cmd_rs, bus.cmd_rt, bus.cmd_imm};
            T_SET:   w_word = {6'b000001, bus.cmd_rs, bus.cmd_rt, bus.cmd_imm};
            default: w_word = 32'h0;
        endcase
    end

    // Look ahead to next cycle's head so the output register holds exactly what the FIFO will present.
    assign w_cnt_kept = r_count - CW'(w_pop);
    assign w_cnt_nxt  = w_cnt_kept + CW'(w_push);
    assign w_rd_nxt   = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;
    assign w_head_nxt = (w_cnt_kept == '0) ? w_word : r_mem[w_rd_nxt];

    assign w_issue_dst = (r_instn[31:26] == 6'b000000) ? r_instn[15:11] : r_instn[20:16];

    always_comb begin
        w_gap_nxt      = r_gap;
        w_last_dst_nxt = r_last_dst;
        if (w_pop) begin
            w_gap_nxt      = 8'd0;
            w_last_dst_nxt = w_issue_dst;
        end else if (bus.instn_ready) begin
            if (r_gap < GAP_MAX) begin
                w_gap_nxt = r_gap + 8'd1;
            end
            if (w_gap_nxt == GAP_MAX) begin
                w_last_dst_nxt = 5'd0;
            end
        end
    end

    assign w_head_is_r  = (w_head_nxt[31:26] == 6'b000000);
    assign w_hazard_nxt = HAZ_EN && (w_last_dst_nxt != 5'd0) &&
                          ((w_head_nxt[25:21] == w_last_dst_nxt) ||
                           (w_head_is_r && (w_head_nxt[20:16] == w_last_dst_nxt)));

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gap      <= 8'd0;
            r_last_dst <= 5'd0;
        end else begin
            r_gap      <= w_gap_nxt;
            r_last_dst <= w_last_dst_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_instn     <= 32'h0;
            r_instn_vld <= 1'b0;
        end else if (w_cnt_nxt == '0) begin
            r_state     <= S_IDLE;
            r_instn     <= 32'h0;
            r_instn_vld <= 1'b0;
        end else if (w_hazard_nxt) begin
            r_state     <= S_BUBBLE;
            r_instn     <= 32'h0;
            r_instn_vld <= 1'b1;
        end else begin
            r_state     <= S_HEAD;
            r_instn     <= w_head_nxt;
            r_instn_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_pulse <= 1'b0;
            r_err_cnt   <= 8'd0;
        end else begin
            r_err_pulse <= w_accept && (bus.cmd_type == T_RSVD);
            if (w_accept && (bus.cmd_type == T_RSVD) && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign bus.cmd_ready   = w_cmd_rdy;
    assign bus.instn       = r_instn;
    assign bus.instn_valid = r_instn_vld;
    assign bus.fifo_count  = r_count;
    assign bus.err_pulse   = r_err_pulse;
    assign bus.err_cnt     = r_err_cnt;
endmodule

// File: tb/tb_instn_encoder.sv
// Directed bench for instn_encoder: encoding, hazard bubbles, backpressure, reserved commands, mid-stream reset.
module tb_instn_encoder;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [31:0] got_q [$];
    logic [31:0] exp_q [$];

    instn_encoder_if #(.DEPTH(4)) bus ();

    instn_encoder #(.DEPTH(4), .HAZ_GAP(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every handshaken word (NOPs included); inputs are stable from negedge to the next posedge.
    always @(negedge clk) begin
        if (!rst && bus.instn_valid && bus.instn_ready) begin
            got_q.push_back(bus.instn);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic send(input logic [1:0] t, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                        input logic [15:0] imm);
        logic acc;
        acc = 1'b0;
        bus.cmd_type  = t;
        bus.cmd_rs    = rs;
        bus.cmd_rt    = rt;
        bus.cmd_rd    = rd;
        bus.cmd_shamt = sh;
        bus.cmd_funct = fn;
        bus.cmd_imm   = imm;
        bus.cmd_valid = 1'b1;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = bus.cmd_ready;
            tick();
        end
        bus.cmd_valid = 1'b0;
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) chk($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_type = 2'd0; bus.cmd_rs = 5'd0; bus.cmd_rt = 5'd0;
        bus.cmd_rd = 5'd0; bus.cmd_shamt = 5'd0; bus.cmd_funct = 6'd0; bus.cmd_imm = 16'd0;
        bus.instn_ready = 1'b0;
        run(3);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst_valid", 32'(bus.instn_valid), 32'd0);
        chk("rst_instn", bus.instn, 32'h0);
        chk("rst_count", 32'(bus.fifo_count), 32'd0);
        chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
        chk("rst_err_pulse", 32'(bus.err_pulse), 32'd0);
        rst = 1'b0;
        bus.instn_ready = 1'b1;
        tick();
        chk("cmd_ready_up", 32'(bus.cmd_ready), 32'd1);

        // ADDI latency: visible right after the accepting edge
        got_q.delete();
        send(2'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'd5);
        chk("t1_valid", 32'(bus.instn_valid), 32'd1);
        chk("t1_word", bus.instn, 32'h20220005);
        chk("t1_count1", 32'(bus.fifo_count), 32'd1);
        tick();
        chk("t1_count0", 32'(bus.fifo_count), 32'd0);
        chk("t1_valid0", 32'(bus.instn_valid), 32'd0);
        run(6);

        // Independent Rtype then SET: no bubbles
        got_q.delete();
        send(2'd0, 5'd2, 5'd3, 5'd4, 5'd0, 6'h20, 16'd0);
        send(2'd2, 5'd0, 5'd7, 5'd0, 5'd0, 6'd0, 16'hFFFF);
        run(6);
        exp_q = '{32'h00432020, 32'h0407FFFF};
        check_stream("t2");

        // Register 0 as producer destination never creates a hazard
        got_q.delete();
        send(2'd1, 5'd5, 5'd0, 5'd0, 5'd0, 6'd0, 16'd1);
        send(2'd0, 5'd0, 5'd0, 5'd9, 5'd0, 6'h20, 16'd0);
        run(6);
        exp_q = '{32'h20A00001, 32'h00004820};
        check_stream("t2_r0");

        // Back-to-back RAW dependency: two NOPs
        got_q.delete();
        send(2'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'd5);
        send(2'd0, 5'd2, 5'd3, 5'd4, 5'd0, 6'h20, 16'd0);
        run(8);
        exp_q = '{32'h20220005, 32'h00000000, 32'h00000000, 32'h00432020};
        check_stream("t3");

        // One idle cycle counts toward the gap: only one NOP
        got_q.delete();
        send(2'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'd5);
        tick();
        send(2'd0, 5'd2, 5'd3, 5'd4, 5'd0, 6'h20, 16'd0);
        run(8);
        exp_q = '{32'h20220005, 32'h00000000, 32'h00432020};
        check_stream("t3_idle");

        // Backpressure: fill to DEPTH, fifth command held
        bus.instn_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(2'd1, 5'd0, 5'(10 + i), 5'd0, 5'd0, 6'd0, 16'(i));
        chk("t4_full_count", 32'(bus.fifo_count), 32'd4);
        chk("t4_full_rdy", 32'(bus.cmd_ready), 32'd0);
        bus.cmd_type = 2'd1; bus.cmd_rs = 5'd0; bus.cmd_rt = 5'd20; bus.cmd_imm = 16'd4;
        bus.cmd_valid = 1'b1;
        run(2);
        chk("t4_hold_count", 32'(bus.fifo_count), 32'd4);
        chk("t4_hold_word", bus.instn, 32'h200A0000);
        chk("t4_hold_valid", 32'(bus.instn_valid), 32'd1);
        got_q.delete();
        bus.instn_ready = 1'b1;
        tick();
        chk("t4_pop_count", 32'(bus.fifo_count), 32'd3);
        chk("t4_pop_rdy", 32'(bus.cmd_ready), 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        chk("t4_pushpop_count", 32'(bus.fifo_count), 32'd3);
        run(8);
        exp_q = '{32'h200A0000, 32'h200B0001, 32'h200C0002, 32'h200D0003, 32'h20140004};
        check_stream("t4");

        // Reserved commands: pulse per command, saturating counter
        got_q.delete();
        for (int i = 0; i < 3; i++) begin
            send(2'd3, 5'd1, 5'd1, 5'd1, 5'd0, 6'd0, 16'd0);
            chk("t5_pulse_hi", 32'(bus.err_pulse), 32'd1);
            chk("t5_no_valid", 32'(bus.instn_valid), 32'd0);
            tick();
            chk("t5_pulse_lo", 32'(bus.err_pulse), 32'd0);
        end
        chk("t5_err_cnt3", 32'(bus.err_cnt), 32'd3);
        chk("t5_no_words", 32'(got_q.size()), 32'd0);
        for (int i = 0; i < 252; i++) send(2'd3, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0);
        tick();
        chk("t5_err_cnt255", 32'(bus.err_cnt), 32'd255);
        for (int i = 0; i < 5; i++) send(2'd3, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0);
        tick();
        chk("t5_err_sat", 32'(bus.err_cnt), 32'd255);

        // Reset while stalled in a bubble
        bus.instn_ready = 1'b0;
        send(2'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'd5);
        send(2'd0, 5'd2, 5'd3, 5'd4, 5'd0, 6'h20, 16'd0);
        send(2'd2, 5'd0, 5'd7, 5'd0, 5'd0, 6'd0, 16'hFFFF);
        bus.instn_ready = 1'b1;
        tick();
        bus.instn_ready = 1'b0;
        tick();
        chk("t6_bubble_valid", 32'(bus.instn_valid), 32'd1);
        chk("t6_bubble_word", bus.instn, 32'h0);
        chk("t6_bubble_count", 32'(bus.fifo_count), 32'd2);
        rst = 1'b1;
        tick();
        chk("t6_rst_valid", 32'(bus.instn_valid), 32'd0);
        chk("t6_rst_count", 32'(bus.fifo_count), 32'd0);
        chk("t6_rst_err", 32'(bus.err_cnt), 32'd0);
        rst = 1'b0;
        bus.instn_ready = 1'b1;
        send(2'd1, 5'd2, 5'd5, 5'd0, 5'd0, 6'd0, 16'h1234);
        chk("t6_post_valid", 32'(bus.instn_valid), 32'd1);
        chk("t6_post_word", bus.instn, 32'h20451234);
        run(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
